// File: rtl/console_pkg.sv
// Shared types and constants for the console receive path.
package console_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int unsigned DIV_RESET_DEFAULT = 53333;
  localparam int unsigned DIV_MIN_DEFAULT   = 4;
  localparam int unsigned RX_VALID_BIT      = 8;

endpackage

// File: rtl/console_rx_if.sv
// CPU-facing register port of the console receiver: divisor register and data pop port.
interface console_rx_if;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_re;
  logic [31:0] reg_dat_do;

  modport master (
    output reg_div_we, reg_div_di, reg_dat_re,
    input  reg_div_do, reg_dat_do
  );

  modport slave (
    input  reg_div_we, reg_div_di, reg_dat_re,
    output reg_div_do, reg_dat_do
  );
endinterface

// File: rtl/console_rx_fifo.sv
// Single-clock byte FIFO; pop ignored when empty, push ignored when full unless a pop frees the slot.
module rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             pop_ok, push_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/console_rx.sv
// 8N1 console receiver: synchroniser, baud counter, framing FSM and byte FIFO behind a polled read port.
module console_rx
  import console_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = DIV_RESET_DEFAULT,
  parameter int DIV_MIN    = DIV_MIN_DEFAULT
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ser_rx,
  console_rx_if.slave                 bus,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        rx_overrun,
  output logic                        rx_frame_err
);

  logic        sync1_q, sync2_q, prev_q;
  logic [31:0] div_q, div_d, eff_div;
  rx_state_e   state_q;
  logic [31:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        overrun_q, ferr_q;
  logic        bit_tick, push, ferr_set, flag_clr;
  logic        fifo_full, fifo_empty;
  logic [7:0]  head_dat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= ser_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    div_d = div_q;
    for (int i = 0; i < 4; i++) begin
      if (bus.reg_div_we[i]) div_d[8*i +: 8] = bus.reg_div_di[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div_q <= 32'(DIV_RESET);
    else         div_q <= div_d;
  end

  assign eff_div        = (div_q < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div_q;
  assign bus.reg_div_do = div_q;

  assign bit_tick = (cnt_q == '0);
  assign push     = (state_q == ST_STOP) && bit_tick && sync2_q;
  assign ferr_set = (state_q == ST_STOP) && bit_tick && !sync2_q;

  // The -1 on each load absorbs the edge-detect and zero-compare cycles so bits stay exactly eff_div apart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (prev_q && !sync2_q) begin
            cnt_q   <= (eff_div >> 1) - 32'd1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            if (!sync2_q) begin
              cnt_q     <= eff_div - 32'd1;
              bit_idx_q <= '0;
              state_q   <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift_q   <= {sync2_q, shift_q[7:1]};
            cnt_q     <= eff_div - 32'd1;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        ST_STOP: begin
          if (bit_tick) state_q <= ST_IDLE;
          else          cnt_q   <= cnt_q - 32'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk        (clk),
    .rst_n      (resetn),
    .push_i     (push),
    .push_dat_i (shift_q),
    .pop_i      (bus.reg_dat_re),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (rx_count)
  );

  // A read strobe on an empty FIFO acknowledges the sticky error flags.
  assign flag_clr = bus.reg_dat_re && fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (flag_clr) begin
        overrun_q <= 1'b0;
        ferr_q    <= 1'b0;
      end
      if (push && fifo_full && !bus.reg_dat_re) overrun_q <= 1'b1;
      if (ferr_set) ferr_q <= 1'b1;
    end
  end

  assign rx_overrun     = overrun_q;
  assign rx_frame_err   = ferr_q;
  assign bus.reg_dat_do = fifo_empty ? 32'h0 : {23'b0, 1'b1, head_dat};

endmodule

// File: tb/tb_console_rx.sv
// Directed bench for console_rx: frames driven bit by bit, results compared against hand-computed words.
module tb_console_rx;
  import console_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ser_rx;
  logic [4:0] rx_count;
  logic       rx_overrun, rx_frame_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  console_rx_if bus ();

  console_rx #(.FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ser_rx       (ser_rx),
    .bus          (bus),
    .rx_count     (rx_count),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int bp);
    ser_rx = b;
    wait_cyc(bp);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int bp);
    send_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) send_bit(d[i], bp);
    send_bit(stop, bp);
    ser_rx = 1'b1;
  endtask

  task automatic write_div(input logic [31:0] v);
    bus.reg_div_we = 4'hF;
    bus.reg_div_di = v;
    wait_cyc(1);
    bus.reg_div_we = 4'h0;
  endtask

  task automatic read_pulse();
    bus.reg_dat_re = 1'b1;
    wait_cyc(1);
    bus.reg_dat_re = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    check(tag, bus.reg_dat_do, exp);
    read_pulse();
  endtask

  initial begin
    resetn         = 1'b0;
    ser_rx         = 1'b1;
    bus.reg_div_we = 4'h0;
    bus.reg_div_di = 32'h0;
    bus.reg_dat_re = 1'b0;
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(2);

    check("rst_dat",   bus.reg_dat_do, 32'h0);
    check("rst_count", 32'(rx_count), 32'd0);
    check("rst_div",   bus.reg_div_do, 32'd53333);
    check("rst_ovr",   32'(rx_overrun), 32'd0);
    check("rst_ferr",  32'(rx_frame_err), 32'd0);

    write_div(32'd16);
    check("div16", bus.reg_div_do, 32'd16);
    send_byte(8'h41, 1'b1, 16);
    wait_cyc(4);
    check("b41_count", 32'(rx_count), 32'd1);
    check("b41_dat",   bus.reg_dat_do, 32'h141);
    read_pulse();
    check("b41_dat_after_pop",   bus.reg_dat_do, 32'h0);
    check("b41_count_after_pop", 32'(rx_count), 32'd0);

    send_byte(8'h00, 1'b1, 16);
    send_byte(8'hFF, 1'b1, 16);
    send_byte(8'h55, 1'b1, 16);
    wait_cyc(4);
    check("b2b_count", 32'(rx_count), 32'd3);
    pop_chk("b2b_00", 32'h100);
    pop_chk("b2b_ff", 32'h1FF);
    pop_chk("b2b_55", 32'h155);
    check("b2b_empty", 32'(rx_count), 32'd0);

    for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b1, 16);
    wait_cyc(4);
    check("ovr_count", 32'(rx_count), 32'd16);
    check("ovr_flag",  32'(rx_overrun), 32'd1);
    for (int i = 1; i <= 16; i++) pop_chk($sformatf("ovr_pop%0d", i), 32'h100 | 32'(i));
    check("ovr_drained", 32'(rx_count), 32'd0);
    check("ovr_sticky",  32'(rx_overrun), 32'd1);
    read_pulse();
    check("ovr_cleared", 32'(rx_overrun), 32'd0);

    send_byte(8'h3C, 1'b0, 16);
    wait_cyc(4);
    check("ferr_count", 32'(rx_count), 32'd0);
    check("ferr_flag",  32'(rx_frame_err), 32'd1);
    check("ferr_novr",  32'(rx_overrun), 32'd0);
    read_pulse();
    check("ferr_cleared", 32'(rx_frame_err), 32'd0);

    ser_rx = 1'b0;
    wait_cyc(3);
    ser_rx = 1'b1;
    wait_cyc(40);
    check("glitch_count", 32'(rx_count), 32'd0);
    check("glitch_ferr",  32'(rx_frame_err), 32'd0);
    check("glitch_ovr",   32'(rx_overrun), 32'd0);

    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b0, 8);
    resetn = 1'b0;
    ser_rx = 1'b1;
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(2);
    check("midrst_count", 32'(rx_count), 32'd0);
    check("midrst_div",   bus.reg_div_do, 32'd53333);
    write_div(32'd16);
    send_byte(8'h5A, 1'b1, 16);
    wait_cyc(4);
    check("midrst_rx_count", 32'(rx_count), 32'd1);
    pop_chk("midrst_5a", 32'h15A);
    check("midrst_empty", 32'(rx_count), 32'd0);

    write_div(32'd2);
    check("clamp_div_raw", bus.reg_div_do, 32'd2);
    send_byte(8'h96, 1'b1, 4);
    send_byte(8'h3B, 1'b1, 4);
    wait_cyc(4);
    check("clamp_count", 32'(rx_count), 32'd2);
    pop_chk("clamp_96", 32'h196);
    pop_chk("clamp_3b", 32'h13B);
    check("clamp_ferr", 32'(rx_frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
